// File: rtl/decoder_defs.sv
// Shared opcode, ALU-code, branch-type and control-word definitions for the pipelined ID stage.
package decoder_defs;

  localparam int OP_NOP   = 0;
  localparam int OP_LDA   = 1;
  localparam int OP_LDB   = 2;
  localparam int OP_LDCA  = 3;
  localparam int OP_LDCB  = 4;
  localparam int OP_STA   = 5;
  localparam int OP_STB   = 6;
  localparam int OP_ADDA  = 7;
  localparam int OP_ADDB  = 8;
  localparam int OP_ADDCA = 9;
  localparam int OP_ADDCB = 10;
  localparam int OP_SUBA  = 11;
  localparam int OP_SUBB  = 12;
  localparam int OP_SUBCA = 13;
  localparam int OP_SUBCB = 14;
  localparam int OP_ANDA  = 15;
  localparam int OP_ANDB  = 16;
  localparam int OP_ANDCA = 17;
  localparam int OP_ANDCB = 18;
  localparam int OP_ORA   = 19;
  localparam int OP_ORB   = 20;
  localparam int OP_ORCA  = 21;
  localparam int OP_ORCB  = 22;
  localparam int OP_JMP   = 23;
  localparam int OP_BEQ   = 24;
  localparam int OP_BNE   = 25;
  localparam int OP_LAST  = OP_BNE;

  localparam logic [2:0] ALU_ADD     = 3'd0;
  localparam logic [2:0] ALU_A_SUB_B = 3'd1;
  localparam logic [2:0] ALU_B_SUB_A = 3'd2;
  localparam logic [2:0] ALU_AND     = 3'd3;
  localparam logic [2:0] ALU_OR      = 3'd4;
  localparam logic [2:0] ALU_DEFAULT = 3'd7;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_JMP  = 2'd1;
  localparam logic [1:0] BR_BEQ  = 2'd2;
  localparam logic [1:0] BR_BNE  = 2'd3;

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} dec_state_e;
  typedef enum logic [1:0] {LD_HOLD, LD_BUBBLE, LD_DECODE} load_sel_e;

  typedef struct packed {
    logic       en_a_id;
    logic       en_b_id;
    logic       en_a_wb;
    logic       en_b_wb;
    logic [2:0] alu;
    logic [1:0] branch;
    logic       sel_a;
    logic       sel_b;
    logic       en_mem;
    logic       mux_wr_mem;
    logic       sel_mem_data;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = '{alu: ALU_DEFAULT, branch: BR_NONE, default: 1'b0};

endpackage

// File: rtl/decoder_ctrl_lut.sv
// Combinational opcode -> control-word mapping, plus which source registers the opcode reads.
// Unknown opcodes map to the NOP control word and raise illegal_o.
module decoder_ctrl_lut
  import decoder_defs::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                reads_a_o,
  output logic                reads_b_o,
  output logic                illegal_o
);

  ctrl_t c;
  int    op;

  always_comb begin
    op        = int'(opcode_i);
    c         = CTRL_BUBBLE;
    reads_a_o = 1'b0;
    reads_b_o = 1'b0;
    case (op)
      OP_LDA:  begin c.en_a_id = 1'b1; c.sel_mem_data = 1'b1; end
      OP_LDB:  begin c.en_b_id = 1'b1; c.sel_mem_data = 1'b1; end
      OP_LDCA: c.en_a_id = 1'b1;
      OP_LDCB: c.en_b_id = 1'b1;
      OP_STA:  begin c.en_mem = 1'b1; reads_a_o = 1'b1; end
      OP_STB:  begin c.en_mem = 1'b1; c.mux_wr_mem = 1'b1; reads_b_o = 1'b1; end
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA: begin
        c.en_a_wb = 1'b1; reads_a_o = 1'b1; reads_b_o = 1'b1;
      end
      OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin
        c.en_b_wb = 1'b1; reads_a_o = 1'b1; reads_b_o = 1'b1;
      end
      // xCA: constant replaces B; xCB: constant replaces A
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA: begin
        c.en_a_wb = 1'b1; c.sel_b = 1'b1; reads_a_o = 1'b1;
      end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin
        c.en_b_wb = 1'b1; c.sel_a = 1'b1; reads_b_o = 1'b1;
      end
      OP_JMP:  c.branch = BR_JMP;
      OP_BEQ:  begin c.branch = BR_BEQ; c.alu = ALU_A_SUB_B; reads_a_o = 1'b1; reads_b_o = 1'b1; end
      OP_BNE:  begin c.branch = BR_BNE; c.alu = ALU_A_SUB_B; reads_a_o = 1'b1; reads_b_o = 1'b1; end
      default: ;
    endcase
    case (op)
      OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB: c.alu = ALU_ADD;
      OP_SUBA, OP_SUBCA:                    c.alu = ALU_A_SUB_B;
      OP_SUBB, OP_SUBCB:                    c.alu = ALU_B_SUB_A;
      OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB: c.alu = ALU_AND;
      OP_ORA, OP_ORB, OP_ORCA, OP_ORCB:     c.alu = ALU_OR;
      default: ;
    endcase
  end

  assign ctrl_o    = c;
  assign illegal_o = (op > OP_LAST);

endmodule

// File: rtl/pipelined_decoder.sv
// Registered ID stage: 1-cycle decode, iStall freezes everything, load-use inserts LOAD_USE_BUBBLES bubbles.
// `define DECODER_ILLEGAL_TRAP_EN turns opcodes above BNE into a bubble plus sticky oIllegal.
module pipelined_decoder
  import decoder_defs::*;
#(
  parameter int INSTR_W          = 16,
  parameter int OPCODE_W         = 6,
  parameter int ALUCTRL_W        = 4,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        iInstrValid,
  input  logic [INSTR_W-1:0]          iMicrocode,
  input  logic                        iStall,
  input  logic                        iFlush,
  output logic                        oInstrReady,
  output logic                        oValid,
  output logic [INSTR_W-OPCODE_W-1:0] oAditional,
  output logic                        oEnableA_ID,
  output logic                        oEnableB_ID,
  output logic                        oEnableA_WB,
  output logic                        oEnableB_WB,
  output logic [ALUCTRL_W-1:0]        oALUControl,
  output logic [1:0]                  oBranchType,
  output logic                        oSelectMuxRegA,
  output logic                        oSelectMuxRegB,
  output logic                        oEnableMem,
  output logic                        oMuxWriteMem,
  output logic                        oSelectInputMemData,
  output logic                        oHazardStall,
  output logic                        oIllegal
);

  localparam int         IMM_W       = INSTR_W - OPCODE_W;
  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_USE_BUBBLES - 1);

`ifdef DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [CTRL_W-1:0] lut_ctrl;
  ctrl_t             dec_ctrl;
  logic              reads_a, reads_b, illegal_op;

  decoder_ctrl_lut #(.OPCODE_W(OPCODE_W)) u_lut (
    .opcode_i  (iMicrocode[INSTR_W-1 -: OPCODE_W]),
    .ctrl_o    (lut_ctrl),
    .reads_a_o (reads_a),
    .reads_b_o (reads_b),
    .illegal_o (illegal_op)
  );
  assign dec_ctrl = lut_ctrl;

  dec_state_e       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic             vld_q, vld_d;
  logic             ill_q, ill_d;
  load_sel_e        load_sel;
  logic             set_ill;
  logic             hazard;

  // Only LDA/LDB combine a register-ID write with the memory-data select.
  assign hazard = iInstrValid && vld_q && ctrl_q.sel_mem_data &&
                  ((ctrl_q.en_a_id && reads_a) || (ctrl_q.en_b_id && reads_b));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!iStall) begin
      if (iFlush) begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (hazard) begin
              cnt_d   = BUBBLE_INIT;
              state_d = (BUBBLE_INIT != 2'd0) ? ST_BUBBLE : ST_RUN;
            end
          end
          ST_BUBBLE: begin
            cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
            if (cnt_q <= 2'd1) state_d = ST_RUN;
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  always_comb begin
    oInstrReady  = !Reset && !iStall && (state_q == ST_RUN) && !hazard;
    oHazardStall = (state_q == ST_BUBBLE);
    set_ill      = 1'b0;
    if (iStall) begin
      load_sel = LD_HOLD;
    end else if (iFlush || (state_q == ST_BUBBLE) || hazard || !iInstrValid) begin
      load_sel = LD_BUBBLE;
    end else if (illegal_op && TRAP_EN) begin
      load_sel = LD_BUBBLE;
      set_ill  = 1'b1;
    end else begin
      load_sel = LD_DECODE;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    imm_d  = imm_q;
    vld_d  = vld_q;
    ill_d  = ill_q | set_ill;
    case (load_sel)
      LD_BUBBLE: begin
        ctrl_d = CTRL_BUBBLE;
        imm_d  = '0;
        vld_d  = 1'b0;
      end
      LD_DECODE: begin
        ctrl_d = dec_ctrl;
        imm_d  = iMicrocode[IMM_W-1:0];
        vld_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ctrl_q <= CTRL_BUBBLE;
      imm_q  <= '0;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      imm_q  <= imm_d;
      vld_q  <= vld_d;
      ill_q  <= ill_d;
    end
  end

  assign oValid              = vld_q;
  assign oAditional          = imm_q;
  assign oEnableA_ID         = ctrl_q.en_a_id;
  assign oEnableB_ID         = ctrl_q.en_b_id;
  assign oEnableA_WB         = ctrl_q.en_a_wb;
  assign oEnableB_WB         = ctrl_q.en_b_wb;
  assign oALUControl         = ALUCTRL_W'(ctrl_q.alu);
  assign oBranchType         = ctrl_q.branch;
  assign oSelectMuxRegA      = ctrl_q.sel_a;
  assign oSelectMuxRegB      = ctrl_q.sel_b;
  assign oEnableMem          = ctrl_q.en_mem;
  assign oMuxWriteMem        = ctrl_q.mux_wr_mem;
  assign oSelectInputMemData = ctrl_q.sel_mem_data;
  assign oIllegal            = ill_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Scoreboard bench for pipelined_decoder: directed scenarios then randomized traffic.
module tb_pipelined_decoder;

  localparam int NB = 2;

`ifdef DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iInstrValid = 1'b0;
  logic [15:0] iMicrocode = '0;
  logic        iStall = 1'b0;
  logic        iFlush = 1'b0;
  logic        oInstrReady, oValid;
  logic [9:0]  oAditional;
  logic        oEnableA_ID, oEnableB_ID, oEnableA_WB, oEnableB_WB;
  logic [3:0]  oALUControl;
  logic [1:0]  oBranchType;
  logic        oSelectMuxRegA, oSelectMuxRegB, oEnableMem, oMuxWriteMem, oSelectInputMemData;
  logic        oHazardStall, oIllegal;

  pipelined_decoder #(.INSTR_W(16), .OPCODE_W(6), .ALUCTRL_W(4), .LOAD_USE_BUBBLES(NB)) dut (
    .Clock(Clock), .Reset(Reset), .iInstrValid(iInstrValid), .iMicrocode(iMicrocode),
    .iStall(iStall), .iFlush(iFlush), .oInstrReady(oInstrReady), .oValid(oValid),
    .oAditional(oAditional), .oEnableA_ID(oEnableA_ID), .oEnableB_ID(oEnableB_ID),
    .oEnableA_WB(oEnableA_WB), .oEnableB_WB(oEnableB_WB), .oALUControl(oALUControl),
    .oBranchType(oBranchType), .oSelectMuxRegA(oSelectMuxRegA), .oSelectMuxRegB(oSelectMuxRegB),
    .oEnableMem(oEnableMem), .oMuxWriteMem(oMuxWriteMem), .oSelectInputMemData(oSelectInputMemData),
    .oHazardStall(oHazardStall), .oIllegal(oIllegal)
  );

  always #5 Clock = ~Clock;

  // flags: {A_ID, B_ID, A_WB, B_WB, muxA, muxB, mem, muxWrMem, selMemData}
  typedef struct packed {
    logic       vld;
    logic [9:0] imm;
    logic [3:0] alu;
    logic [1:0] br;
    logic [8:0] flags;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t cur;
  int   m_bub = 0;
  bit   m_ld_a = 0, m_ld_b = 0, m_ill_next = 0;
  bit   exp_rdy = 0, exp_hs = 0;
  bit   rdy_seen = 0, hs_seen = 0;
  bit   stall_e = 0, rst_e = 1, ill_e = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t bubble_exp();
    exp_t e;
    e = '0;
    e.alu = 4'd7;
    return e;
  endfunction

  // ALU ops 7..22 come in groups of four: {xA, xB, xCA, xCB} for ADD, SUB, AND, OR.
  function automatic bit reads_a(input int op);
    if (op >= 7 && op <= 22) return ((op - 7) % 4) != 3;
    return op == 5 || op == 24 || op == 25;
  endfunction

  function automatic bit reads_b(input int op);
    if (op >= 7 && op <= 22) return ((op - 7) % 4) != 2;
    return op == 6 || op == 24 || op == 25;
  endfunction

  function automatic exp_t ref_decode(input int op, input int imm);
    exp_t e;
    bit a_id, b_id, a_wb, b_wb, sa, sb, mem, mw, smd;
    int fam, v;
    e = bubble_exp();
    e.vld = 1'b1;
    e.imm = imm[9:0];
    {a_id, b_id, a_wb, b_wb, sa, sb, mem, mw, smd} = '0;
    if (op == 1) begin a_id = 1; smd = 1; end
    else if (op == 2) begin b_id = 1; smd = 1; end
    else if (op == 3) a_id = 1;
    else if (op == 4) b_id = 1;
    else if (op == 5) mem = 1;
    else if (op == 6) begin mem = 1; mw = 1; end
    else if (op >= 7 && op <= 22) begin
      fam = (op - 7) / 4;
      v   = (op - 7) % 4;
      if (v == 0 || v == 2) a_wb = 1; else b_wb = 1;
      sb = (v == 2);
      sa = (v == 3);
      case (fam)
        0: e.alu = 4'd0;
        1: e.alu = (v == 0 || v == 2) ? 4'd1 : 4'd2;
        2: e.alu = 4'd3;
        default: e.alu = 4'd4;
      endcase
    end
    else if (op == 23) e.br = 2'd1;
    else if (op == 24) begin e.br = 2'd2; e.alu = 4'd1; end
    else if (op == 25) begin e.br = 2'd3; e.alu = 4'd1; end
    e.flags = {a_id, b_id, a_wb, b_wb, sa, sb, mem, mw, smd};
    return e;
  endfunction

  // Called just after a rising edge; presents one cycle of stimulus and advances the model.
  task automatic cycle(input bit v, input int op, input int imm, input bit st, input bit fl);
    bit hz;
    iInstrValid = v;
    iMicrocode  = {op[5:0], imm[9:0]};
    iStall      = st;
    iFlush      = fl;
    hz      = v && ((m_ld_a && reads_a(op)) || (m_ld_b && reads_b(op)));
    exp_hs  = (m_bub > 0);
    exp_rdy = !st && (m_bub == 0) && !hz;
    if (!st) begin
      if (fl || m_bub > 0 || hz || !v || (op > 25 && TRAP)) begin
        if (fl) m_bub = 0;
        else if (m_bub > 0) m_bub--;
        else if (hz) m_bub = NB - 1;
        else if (v && op > 25) m_ill_next = 1;
        m_ld_a = 0;
        m_ld_b = 0;
      end else begin
        sb_q.push_back(ref_decode(op, imm));
        m_ld_a = (op == 1);
        m_ld_b = (op == 2);
      end
    end
    @(negedge Clock);
    rdy_seen = oInstrReady;
    hs_seen  = oHazardStall;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; iInstrValid = 1'b1; iStall = 1'b0; iFlush = 1'b0;
    iMicrocode = 16'h1C00;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk("rst_valid", oValid, 0);
    chk("rst_alu", oALUControl, 7);
    chk("rst_fields", {oAditional, oBranchType, oEnableA_ID, oEnableB_ID, oEnableA_WB, oEnableB_WB,
        oSelectMuxRegA, oSelectMuxRegB, oEnableMem, oMuxWriteMem, oSelectInputMemData}, 0);
    chk("rst_ready", oInstrReady, 0);
    chk("rst_hzstall", oHazardStall, 0);
    chk("rst_illegal", oIllegal, 0);
    sb_q.delete();
    m_bub = 0; m_ld_a = 0; m_ld_b = 0; m_ill_next = 0;
    cur = bubble_exp();
    Reset = 1'b0; iInstrValid = 1'b0;
  endtask

  always @(posedge Clock) begin
    stall_e <= iStall;
    rst_e   <= Reset;
    ill_e   <= m_ill_next;
  end

  always @(negedge Clock) begin
    if (!rst_e && !Reset) begin
      chk("ready", oInstrReady, exp_rdy);
      chk("hazard_stall", oHazardStall, exp_hs);
      if (!stall_e) begin
        if (oValid) begin
          chk("sb_nonempty", sb_q.size() != 0, 1);
          cur = (sb_q.size() != 0) ? sb_q.pop_front() : bubble_exp();
        end else begin
          cur = bubble_exp();
        end
      end
      chk("valid", oValid, cur.vld);
      chk("imm", oAditional, cur.imm);
      chk("alu", oALUControl, cur.alu);
      chk("branch", oBranchType, cur.br);
      chk("ctrl_flags", {oEnableA_ID, oEnableB_ID, oEnableA_WB, oEnableB_WB, oSelectMuxRegA,
          oSelectMuxRegB, oEnableMem, oMuxWriteMem, oSelectInputMemData}, cur.flags);
      chk("illegal", oIllegal, ill_e);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, hs_cnt, op, r;
    bit v, st, fl;
    cur = bubble_exp();
    do_reset();

    cycle(1, 9, 5, 0, 0);
    chk("addca_valid", oValid, 1);
    chk("addca_imm", oAditional, 5);
    chk("addca_muxb", oSelectMuxRegB, 1);
    cycle(0, 0, 0, 0, 0);

    // load-use: count cycles the held ADDA is refused
    cycle(1, 1, 3, 0, 0);
    low_cnt = 0;
    hs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 7, 4, 0, 0);
      if (hs_seen) hs_cnt++;
      if (rdy_seen) break;
      low_cnt++;
    end
    chk("lu_ready_low_cycles", low_cnt, NB);
    chk("lu_hzstall_cycles", hs_cnt, NB - 1);
    chk("lu_adda_wb", oEnableA_WB, 1);

    cycle(1, 1, 8, 0, 0);
    cycle(1, 10, 9, 0, 0);
    chk("lda_addcb_no_hazard", rdy_seen, 1);
    cycle(0, 0, 0, 0, 0);

    cycle(1, 24, 7, 0, 1);
    chk("flush_valid", oValid, 0);
    chk("flush_branch", oBranchType, 0);
    cycle(1, 23, 9, 0, 0);
    chk("jmp_branch", oBranchType, 1);

    cycle(1, 12, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 7, 0, 1, 0);
      chk("stall_ready", rdy_seen, 0);
      chk("stall_b_wb", oEnableB_WB, 1);
      chk("stall_alu", oALUControl, 2);
    end
    cycle(0, 0, 0, 0, 0);

    // reset while the FSM sits in BUBBLE
    cycle(1, 1, 1, 0, 0);
    cycle(1, 7, 1, 0, 0);
    do_reset();
    cycle(1, 7, 1, 0, 0);
    chk("post_rst_ready", rdy_seen, 1);

    cycle(1, 40, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("illegal_set", oIllegal, TRAP);
    cycle(1, 3, 2, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("illegal_sticky", oIllegal, TRAP);
    do_reset();

    for (int n = 0; n < 900; n++) begin
      if (n % 300 == 299) do_reset();
      v  = ($urandom % 100) < 85;
      r  = $urandom % 100;
      if (r < 25) op = (r % 2) ? 1 : 2;
      else if (r < 95) op = $urandom_range(0, 25);
      else op = $urandom_range(26, 63);
      st = ($urandom % 100) < 15;
      fl = ($urandom % 100) < 7;
      cycle(v, op, $urandom_range(0, 1023), st, fl);
    end

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
